// File: rtl/cmd_frame_controller.sv
// Command/response controller for the 16-bit serial host link.
// Each received frame is {opcode, argument}. The frame updates the control
// registers and returns one response word from the selected readback channel.
module cmd_frame_controller #(
    parameter int unsigned    DW         = 16,
    parameter int unsigned    NCH        = 8,
    parameter int unsigned    ADDRW      = 8,
    parameter int unsigned    RD_LAT     = 2,
    parameter int unsigned    ADDR_OP_LO = 5,
    parameter int unsigned    ADDR_OP_HI = 7,
    parameter int unsigned    NOPS       = 9,
    parameter logic [DW-1:0]  ACK        = DW'(16'h002B)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                RXDV,
    input  logic [DW-1:0]       RX,
    input  logic [NCH*DW-1:0]   ChData,
    output logic                TXDV,
    output logic [DW-1:0]       TX,
    output logic [DW/2-1:0]     Mode,
    output logic [DW-1:0]       Uupr,
    output logic [DW-1:0]       D,
    output logic [ADDRW-1:0]    AddrRAM,
    output logic                RAMRdEn,
    output logic [7:0]          ErrCnt
);

    localparam int unsigned OPW = DW / 2;

    // RXDV synchroniser and edge detector
    logic           s1;
    logic           s2;
    logic           prev;
    logic           frame_evt;

    // Captured frame, valid on the cycle after the frame event
    logic [DW-1:0]  frame_q;
    logic           frame_v;
    logic [OPW-1:0] op;
    logic [OPW-1:0] arg;

    // Pair-sequencing state
    logic [OPW-1:0] half_u;
    logic [OPW-1:0] half_d;
    logic           pend_u;
    logic           pend_d;

    // Decode results (next values for the control registers)
    logic [OPW-1:0]   mode_n;
    logic [DW-1:0]    uupr_n;
    logic [DW-1:0]    d_n;
    logic [ADDRW-1:0] addr_n;
    logic [OPW-1:0]   half_u_n;
    logic [OPW-1:0]   half_d_n;
    logic             pend_u_n;
    logic             pend_d_n;
    logic             err_inc;
    logic             op_illegal;
    logic             op_addr;

    // Response pipeline: opcode and valid delayed to match the RAM read latency
    logic [RD_LAT-1:0]          pipe_v;
    logic [RD_LAT-1:0][OPW-1:0] pipe_op;
    logic [DW-1:0]              resp_sel;

    assign frame_evt  = s2 & ~prev;
    assign op         = frame_q[DW-1:OPW];
    assign arg        = frame_q[OPW-1:0];
    assign op_illegal = (op >= OPW'(NOPS));
    assign op_addr    = (op >= OPW'(ADDR_OP_LO)) && (op <= OPW'(ADDR_OP_HI));

    // Synchronise RXDV and capture RX on its rising edge; flops preset to 1 so
    // a level already high at reset release is not taken as a frame
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            prev    <= 1'b1;
            frame_v <= 1'b0;
            frame_q <= '0;
        end else begin
            s1      <= RXDV;
            s2      <= s1;
            prev    <= s2;
            frame_v <= frame_evt;
            if (frame_evt) begin
                frame_q <= RX;
            end
        end
    end

    // Decode the captured frame into next register values
    always_comb begin
        mode_n   = Mode;
        uupr_n   = Uupr;
        d_n      = D;
        addr_n   = AddrRAM;
        half_u_n = half_u;
        half_d_n = half_d;
        pend_u_n = pend_u;
        pend_d_n = pend_d;
        err_inc  = 1'b0;
        if (frame_v) begin
            // Any frame breaks an open pair unless it is that pair's own opcode
            addr_n   = '0;
            pend_u_n = 1'b0;
            pend_d_n = 1'b0;
            if (op_illegal) begin
                uupr_n  = '0;
                d_n     = '0;
                err_inc = 1'b1;
            end else if (op == OPW'(0)) begin
                mode_n = arg;
            end else if (op == OPW'(1)) begin
                half_u_n = arg;
                pend_u_n = 1'b1;
            end else if (op == OPW'(2)) begin
                if (pend_u) begin
                    uupr_n = {half_u, arg};
                end else begin
                    err_inc = 1'b1;
                end
            end else if (op == OPW'(3)) begin
                half_d_n = arg;
                pend_d_n = 1'b1;
            end else if (op == OPW'(4)) begin
                if (pend_d) begin
                    d_n = {half_d, arg};
                end else begin
                    err_inc = 1'b1;
                end
            end else if (op_addr) begin
                addr_n = arg[ADDRW-1:0];
            end
        end
    end

    // Control registers, pair state, RAM read strobe and error counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Mode    <= '0;
            Uupr    <= '0;
            D       <= '0;
            AddrRAM <= '0;
            RAMRdEn <= 1'b0;
            ErrCnt  <= '0;
            half_u  <= '0;
            half_d  <= '0;
            pend_u  <= 1'b0;
            pend_d  <= 1'b0;
        end else begin
            Mode    <= mode_n;
            Uupr    <= uupr_n;
            D       <= d_n;
            AddrRAM <= addr_n;
            RAMRdEn <= frame_v;
            half_u  <= half_u_n;
            half_d  <= half_d_n;
            pend_u  <= pend_u_n;
            pend_d  <= pend_d_n;
            if (err_inc && (ErrCnt != 8'hFF)) begin
                ErrCnt <= ErrCnt + 8'd1;
            end
        end
    end

    // Shift opcode/valid through RD_LAT stages; one new entry per cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pipe_v  <= '0;
            pipe_op <= '0;
        end else begin
            pipe_v[0]  <= frame_v;
            pipe_op[0] <= op;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_op[i] <= pipe_op[i-1];
            end
        end
    end

    // Select the readback channel live at the response edge, ACK otherwise
    always_comb begin
        resp_sel = ACK;
        for (int k = 0; k < int'(NCH); k++) begin
            if (pipe_op[RD_LAT-1] == OPW'(k)) begin
                resp_sel = ChData[k*DW +: DW];
            end
        end
    end

    // Response register: TX holds its value between strobes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            TXDV <= 1'b0;
            TX   <= '0;
        end else begin
            TXDV <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                TX <= resp_sel;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_controller.sv
// Bench for cmd_frame_controller: scenario tasks with inline checks plus a
// response scoreboard fed at frame send time and drained on every TXDV.
module tb_cmd_frame_controller;

    localparam int unsigned DW    = 16;
    localparam int unsigned NCH   = 8;
    localparam int unsigned ADDRW = 8;

    logic                Clock = 1'b0;
    logic                Reset;
    logic                RXDV;
    logic [DW-1:0]       RX;
    logic [NCH*DW-1:0]   ChData;
    logic                TXDV;
    logic [DW-1:0]       TX;
    logic [DW/2-1:0]     Mode;
    logic [DW-1:0]       Uupr;
    logic [DW-1:0]       D;
    logic [ADDRW-1:0]    AddrRAM;
    logic                RAMRdEn;
    logic [7:0]          ErrCnt;

    logic [DW-1:0] ch_val [NCH];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    cmd_frame_controller dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .RXDV    (RXDV),
        .RX      (RX),
        .ChData  (ChData),
        .TXDV    (TXDV),
        .TX      (TX),
        .Mode    (Mode),
        .Uupr    (Uupr),
        .D       (D),
        .AddrRAM (AddrRAM),
        .RAMRdEn (RAMRdEn),
        .ErrCnt  (ErrCnt)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        ChData = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            ChData[k*DW +: DW] = ch_val[k];
        end
    end

    // Expected response for a frame: channel data for low opcodes, ACK otherwise
    function automatic logic [DW-1:0] exp_tx(input logic [DW-1:0] rx);
        logic [7:0] op;
        op = rx[15:8];
        if (op < 8'd8) return ch_val[op[2:0]];
        return 16'h002B;
    endfunction

    // Scoreboard: every TXDV must match the oldest outstanding expectation
    always @(negedge Clock) begin
        if (TXDV === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %h with no frame outstanding", TX);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (TX !== e) begin
                    errors++;
                    $display("FAIL tx_data got %h want %h", TX, e);
                end
            end
        end
    end

    // RXDV high one cycle, RX held until after the capture edge
    task automatic send_frame(input logic [DW-1:0] rx, input bit push);
        @(negedge Clock);
        RX   = rx;
        RXDV = 1'b1;
        if (push) exp_q.push_back(exp_tx(rx));
        @(negedge Clock);
        RXDV = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge Clock);
            n++;
        end
        repeat (3) @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding got %0d want 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        RXDV  = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        RXDV  = 1'b0;
        RX    = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({TXDV, TX, Mode, Uupr, D, AddrRAM, RAMRdEn, ErrCnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got txdv=%b tx=%h mode=%h uupr=%h d=%h addr=%h rd=%b err=%h want all 0",
                     TXDV, TX, Mode, Uupr, D, AddrRAM, RAMRdEn, ErrCnt);
        end
    endtask

    // Timing of the first frame: decode after t0+3, response after t0+5
    task automatic test_mode();
        send_frame(16'h0005, 1'b1);
        checks++;
        if (Mode !== 8'h00) begin errors++; $display("FAIL mode_early got %h want 00", Mode); end
        @(negedge Clock);
        checks++;
        if (Mode !== 8'h05) begin errors++; $display("FAIL mode_set got %h want 05", Mode); end
        checks++;
        if (RAMRdEn !== 1'b1) begin errors++; $display("FAIL mode_rden got %b want 1", RAMRdEn); end
        @(negedge Clock);
        checks++;
        if (TXDV !== 1'b0 || RAMRdEn !== 1'b0) begin
            errors++; $display("FAIL mode_t4 got txdv=%b rden=%b want 0 0", TXDV, RAMRdEn);
        end
        @(negedge Clock);
        checks++;
        if (TXDV !== 1'b1 || TX !== ch_val[0]) begin
            errors++; $display("FAIL mode_tx got txdv=%b tx=%h want 1 %h", TXDV, TX, ch_val[0]);
        end
        @(negedge Clock);
        checks++;
        if (TXDV !== 1'b0 || TX !== ch_val[0]) begin
            errors++; $display("FAIL mode_tx_hold got txdv=%b tx=%h want 0 %h", TXDV, TX, ch_val[0]);
        end
        wait_drain();
    endtask

    task automatic test_pair_broken();
        do_reset();
        send_frame(16'h0112, 1'b1);
        send_frame(16'h0000, 1'b1);
        send_frame(16'h0234, 1'b1);
        wait_drain();
        checks++;
        if (Uupr !== 16'h0000 || ErrCnt !== 8'd1 || Mode !== 8'h00) begin
            errors++;
            $display("FAIL pair_broken got uupr=%h err=%0d mode=%h want 0000 1 00", Uupr, ErrCnt, Mode);
        end
    endtask

    task automatic test_pairs();
        do_reset();
        send_frame(16'h01AB, 1'b1);
        send_frame(16'h02CD, 1'b1);
        send_frame(16'h0301, 1'b1);
        send_frame(16'h0402, 1'b1);
        wait_drain();
        checks++;
        if (Uupr !== 16'hABCD || D !== 16'h0102 || ErrCnt !== 8'd0) begin
            errors++;
            $display("FAIL pairs got uupr=%h d=%h err=%0d want abcd 0102 0", Uupr, D, ErrCnt);
        end
        send_frame(16'h0111, 1'b1);
        send_frame(16'h0122, 1'b1);
        send_frame(16'h0233, 1'b1);
        send_frame(16'h0477, 1'b1);
        wait_drain();
        checks++;
        if (Uupr !== 16'h2233 || D !== 16'h0102 || ErrCnt !== 8'd1) begin
            errors++;
            $display("FAIL pair_repeat got uupr=%h d=%h err=%0d want 2233 0102 1", Uupr, D, ErrCnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send_frame(16'h01AB, 1'b1);
        send_frame(16'h02CD, 1'b1);
        send_frame(16'h0301, 1'b1);
        send_frame(16'h0402, 1'b1);
        send_frame(16'h0655, 1'b1);
        send_frame(16'h0A00, 1'b1);
        wait_drain();
        checks++;
        if (Uupr !== 16'h0000 || D !== 16'h0000 || ErrCnt !== 8'd1 || AddrRAM !== 8'h00) begin
            errors++;
            $display("FAIL illegal got uupr=%h d=%h err=%0d addr=%h want 0000 0000 1 00", Uupr, D, ErrCnt, AddrRAM);
        end
    endtask

    task automatic test_addr();
        do_reset();
        ch_val[6] = 16'h1234;
        send_frame(16'h0640, 1'b1);
        checks++;
        if (RAMRdEn !== 1'b0) begin errors++; $display("FAIL addr_rden_early got %b want 0", RAMRdEn); end
        @(negedge Clock);
        checks++;
        if (AddrRAM !== 8'h40 || RAMRdEn !== 1'b1) begin
            errors++; $display("FAIL addr_load got addr=%h rden=%b want 40 1", AddrRAM, RAMRdEn);
        end
        @(negedge Clock);
        checks++;
        if (RAMRdEn !== 1'b0) begin errors++; $display("FAIL addr_rden_pulse got %b want 0", RAMRdEn); end
        @(negedge Clock);
        checks++;
        if (TXDV !== 1'b1 || TX !== 16'h1234) begin
            errors++; $display("FAIL addr_tx got txdv=%b tx=%h want 1 1234", TXDV, TX);
        end
        send_frame(16'h07FF, 1'b1);
        send_frame(16'h0500, 1'b1);
        send_frame(16'h0855, 1'b1);
        wait_drain();
        checks++;
        if (AddrRAM !== 8'h00 || ErrCnt !== 8'd0 || TX !== 16'h002B) begin
            errors++; $display("FAIL addr_op8 got addr=%h err=%0d tx=%h want 00 0 002b", AddrRAM, ErrCnt, TX);
        end
    endtask

    // Frames three cycles apart, several responses in flight at once
    task automatic test_back_to_back();
        logic [DW-1:0] seq [6];
        do_reset();
        seq = '{16'h0701, 16'h0102, 16'h0203, 16'h0504, 16'h0805, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            RX   = seq[i];
            RXDV = 1'b1;
            exp_q.push_back(exp_tx(seq[i]));
            @(negedge Clock);
            RXDV = 1'b0;
            @(negedge Clock);
        end
        wait_drain();
        checks++;
        if (Uupr !== 16'h0203 || AddrRAM !== 8'h00 || ErrCnt !== 8'd0) begin
            errors++; $display("FAIL b2b_regs got uupr=%h addr=%h err=%0d want 0203 00 0", Uupr, AddrRAM, ErrCnt);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_frame(16'h0C00, 1'b1);
        end
        wait_drain();
        checks++;
        if (ErrCnt !== 8'd255) begin errors++; $display("FAIL err_saturate got %0d want 255", ErrCnt); end
    endtask

    task automatic test_reset_held();
        int seen;
        @(negedge Clock);
        Reset = 1'b1;
        RX    = 16'h0033;
        RXDV  = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(negedge Clock);
            if (TXDV === 1'b1) seen++;
        end
        RXDV = 1'b0;
        repeat (8) begin
            @(negedge Clock);
            if (TXDV === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || Mode !== 8'h00 || RAMRdEn !== 1'b0) begin
            errors++; $display("FAIL reset_held got txdv_count=%0d mode=%h want 0 00", seen, Mode);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        send_frame(16'h0077, 1'b0);
        @(negedge Clock);
        checks++;
        if (Mode !== 8'h77) begin errors++; $display("FAIL midflight_decode got %h want 77", Mode); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        seen  = 0;
        repeat (10) begin
            @(negedge Clock);
            if (TXDV === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || {TXDV, TX, Mode, Uupr, D, AddrRAM, RAMRdEn, ErrCnt} !== '0) begin
            errors++;
            $display("FAIL midflight_reset got txdv_count=%0d mode=%h tx=%h want 0 and all outputs 0", seen, Mode, TX);
        end
    endtask

    initial begin
        for (int k = 0; k < int'(NCH); k++) ch_val[k] = 16'hC000 + 16'(k * 16'h0111);
        test_reset();
        test_mode();
        test_pair_broken();
        test_pairs();
        test_illegal();
        test_addr();
        test_back_to_back();
        test_err_saturate();
        test_reset_held();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_queue got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
